dp_serial_add: RTL and testbench
================================

Name: dp_serial_add

Overview:
- Multi-cycle, bit-serial adder for the sort datapath; the additive inverse of the combinational subtractor.
- Adds two datawidth-bit operands one bit per clock, LSB first, with a registered carry.
- Restores values from differences (c = diff + b) and performs index/offset addition where a full-width combinational adder is not wanted.
- Start/busy/done handshake toward the sort controller.

Parameters:
- datawidth, 8, operand and result width in bits (>= 2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled on the clk edge when the block is not busy.
- a  input  datawidth  operand A; captured on the accepting edge only.
- b  input  datawidth  operand B; captured on the accepting edge only.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; c and cout are valid from this cycle.
- c  output  datawidth  registered sum (a+b) mod 2^datawidth.
- cout  output  1  registered carry-out of the sum.

Behaviour:
- Reset is asynchronous and active-high; it applies immediately, independent of clk.
  - state=IDLE; busy=0, done=0, c=0, cout=0; internal shift registers, carry and bit counter = 0.
  - Reset mid-RUN abandons the operation. No done is produced and c is not updated.
- States: IDLE, RUN, DONE. Encoding is registered; outputs decode from state and registers only (no input-to-output combinational path).
- IDLE:
  - start=1 → latch a into sa and b into sb; carry=0; cnt=0; go to RUN.
  - start=0 → stay in IDLE.
- RUN (busy=1), each edge:
  - s = sa[0]^sb[0]^carry.
  - carry = majority(sa[0], sb[0], carry).
  - sum shift register shifts right with s entering at the MSB; sa and sb shift right; cnt increments.
  - On the edge where cnt == datawidth-1: load c with the completed sum, load cout with the final carry, go to DONE.
  - start is ignored in RUN; a and b may change freely without effect.
- DONE (done=1, busy=0), lasts one cycle:
  - start=1 → accepted exactly as in IDLE (back-to-back operation), go to RUN.
  - start=0 → go to IDLE.
- Latency: start accepted at edge E0 → done is high in the cycle following edge E0+datawidth. For datawidth=8, that is 8 edges after acceptance.
- Throughput: one result per datawidth+1 cycles with start held high continuously.
- c and cout hold their last value until the next DONE entry or reset. They never show partial sums.
- Arithmetic: unsigned modulo 2^datawidth.
  - Overflow is reported only via cout.
  - Two's-complement wrap-around is natural: c = a + b with the carry discarded.
- Counter width: clog2(datawidth); cnt never exceeds datawidth-1.

Decomposition:
- Shared package (dp_pkg): state encoding constants for IDLE/RUN/DONE and a count-width function/constant derived from datawidth. The controller FSMs of the sort design reuse the same handshake encoding.
- One natural sub-module: dp_fa, a 1-bit combinational full adder (a, b, cin → s, cout). It is instantiated once for the serial bit slice.

Test Plan:
- Reset: assert rst mid-RUN of 0x12+0x34 → busy, done, c and cout go to 0 immediately, no done pulse follows; after release, 0x12+0x34 → c=0x46, cout=0, done exactly 8 edges after acceptance.
- Wrap-around: a=0xFF, b=0x01 → c=0x00, cout=1; a=0xFF, b=0xFF → c=0xFE, cout=1.
- Inverse of subtractor: a=0x2A, b=0x35 (diff 0x2A-0x35=0xF5); then add 0xF5+0x35 → c=0x2A, cout=1.
- Handshake: pulse start during RUN with a=0x01, b=0x01 → ignored, first result (0x10+0x20=0x30) unaffected; change a/b during RUN → no effect on c.
- Back-to-back: hold start=1 with operand pairs (3,4), (100,200) → done pulses 9 cycles apart; c=0x07/cout=0, then c=0x2C/cout=1.
- Zero and datawidth=4 instance: 0+0 → c=0, cout=0; 4-bit 0xF+0x1 → c=0x0, cout=1, done 4 edges after acceptance.

Source files
------------

// File: rtl/dp_pkg.sv
// Shared encodings for the sort datapath: handshake FSM states and counter sizing.
package dp_pkg;

  typedef enum logic [1:0] {
    st_idle = 2'd0,
    st_run  = 2'd1,
    st_done = 2'd2
  } dp_state_t;

  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/dp_serial_add_if.sv
// Start/busy/done handshake and operand/result bus of the bit-serial adder.
interface dp_serial_add_if #(parameter int datawidth = 8);
  logic                 start;
  logic [datawidth-1:0] a;
  logic [datawidth-1:0] b;
  logic                 busy;
  logic                 done;
  logic [datawidth-1:0] c;
  logic                 cout;

  modport master (output start, a, b, input busy, done, c, cout);
  modport slave  (input start, a, b, output busy, done, c, cout);
endinterface

// File: rtl/dp_fa.sv
// One-bit combinational full adder, used as the serial bit slice.
module dp_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/dp_serial_add.sv
// Bit-serial adder, LSB first with a registered carry; c/cout update only on completion.
// state | meaning
// idle  | waiting for start
// run   | one operand bit per clock, busy high
// done  | one-cycle result pulse, may accept the next start
module dp_serial_add
  import dp_pkg::*;
#(
  parameter int datawidth = 8
) (
  input logic            clk,
  input logic            rst,
  dp_serial_add_if.slave bus
);
  localparam int cw = cnt_width(datawidth);
  localparam logic [cw-1:0] last_cnt = cw'(datawidth - 1);

  dp_state_t            state;
  logic [datawidth-1:0] sa, sb, sum, c_r;
  logic [cw-1:0]        cnt;
  logic                 carry, cout_r, busy_r, done_r;
  logic                 s_bit, c_bit;
  logic [datawidth-1:0] sum_next;

  dp_fa u_fa (
    .a    (sa[0]),
    .b    (sb[0]),
    .cin  (carry),
    .s    (s_bit),
    .cout (c_bit)
  );

  assign sum_next = {s_bit, sum[datawidth-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= st_idle;
      sa     <= '0;
      sb     <= '0;
      sum    <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      c_r    <= '0;
      cout_r <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      case (state)
        st_idle, st_done: begin
          done_r <= 1'b0;
          if (bus.start) begin
            sa     <= bus.a;
            sb     <= bus.b;
            sum    <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy_r <= 1'b1;
            state  <= st_run;
          end else begin
            busy_r <= 1'b0;
            state  <= st_idle;
          end
        end
        st_run: begin
          carry <= c_bit;
          sum   <= sum_next;
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          if (cnt == last_cnt) begin
            // the final bit is still in flight, so take it straight from the slice
            c_r    <= sum_next;
            cout_r <= c_bit;
            cnt    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b1;
            state  <= st_done;
          end else begin
            cnt <= cnt + cw'(1);
          end
        end
        default: begin
          busy_r <= 1'b0;
          done_r <= 1'b0;
          state  <= st_idle;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.c    = c_r;
  assign bus.cout = cout_r;
endmodule

// File: tb/tb_dp_serial_add.sv
// Self-checking bench for dp_serial_add: directed corner cases plus random operands, 8- and 4-bit.
module tb_dp_serial_add;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  dp_serial_add_if #(.datawidth(8)) bus8 ();
  dp_serial_add_if #(.datawidth(4)) bus4 ();

  dp_serial_add #(.datawidth(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  dp_serial_add #(.datawidth(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One 8-bit operation; optionally pokes start with 1+1 mid-run to prove it is ignored.
  task automatic op8(input logic [7:0] x, input logic [7:0] y, input bit poke, input string tag);
    logic [8:0] exp;
    logic [7:0] prev_c;
    int n;
    exp    = {1'b0, x} + {1'b0, y};
    prev_c = bus8.c;
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = x; bus8.b = y;
    @(posedge clk); #1;
    chk({tag, " busy"}, 32'(bus8.busy), 32'd1);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      bus8.a     = 8'($urandom);
      bus8.b     = 8'($urandom);
      bus8.start = poke && (i == 3);
      if (poke && i == 3) begin bus8.a = 8'h01; bus8.b = 8'h01; end
      @(posedge clk); #1;
      if (i == 4) chk({tag, " c held"}, 32'(bus8.c), 32'(prev_c));
      if (bus8.done) begin n = i; break; end
    end
    if (n == 0) n = 99;
    chk({tag, " latency"}, n, 8);
    chk({tag, " c"}, 32'(bus8.c), 32'(exp[7:0]));
    chk({tag, " cout"}, 32'(bus8.cout), 32'(exp[8]));
    @(negedge clk);
    bus8.start = 1'b0;
    @(posedge clk); #1;
    chk({tag, " done pulse"}, 32'(bus8.done), 32'd0);
  endtask

  task automatic op4(input logic [3:0] x, input logic [3:0] y, input string tag);
    logic [4:0] exp;
    int n;
    exp = {1'b0, x} + {1'b0, y};
    @(negedge clk);
    bus4.start = 1'b1; bus4.a = x; bus4.b = y;
    @(posedge clk); #1;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      bus4.start = 1'b0;
      bus4.a = 4'($urandom);
      bus4.b = 4'($urandom);
      @(posedge clk); #1;
      if (bus4.done) begin n = i; break; end
    end
    if (n == 0) n = 99;
    chk({tag, " latency"}, n, 4);
    chk({tag, " c"}, 32'(bus4.c), 32'(exp[3:0]));
    chk({tag, " cout"}, 32'(bus4.cout), 32'(exp[4]));
  endtask

  initial begin
    int dcount;
    int d1, d2;
    logic [7:0] c1, c2;
    logic       o1, o2;

    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;
    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", 32'(bus8.busy), 32'd0);
    chk("reset done", 32'(bus8.done), 32'd0);
    chk("reset c", 32'(bus8.c), 32'd0);
    chk("reset cout", 32'(bus8.cout), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    op8(8'hFF, 8'hFF, 1'b0, "ff+ff");

    // asynchronous reset in the middle of a run
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'h12; bus8.b = 8'h34;
    @(posedge clk); #1;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("midrun rst busy", 32'(bus8.busy), 32'd0);
    chk("midrun rst done", 32'(bus8.done), 32'd0);
    chk("midrun rst c", 32'(bus8.c), 32'd0);
    chk("midrun rst cout", 32'(bus8.cout), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus8.done) dcount++;
    end
    chk("no done after rst", dcount, 0);

    op8(8'h12, 8'h34, 1'b0, "12+34");
    op8(8'hFF, 8'h01, 1'b0, "ff+01");
    op8(8'hF5, 8'h35, 1'b0, "f5+35");
    op8(8'h10, 8'h20, 1'b1, "10+20 poke");
    op8(8'h00, 8'h00, 1'b0, "00+00");

    // back-to-back with start held high
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'd3; bus8.b = 8'd4;
    @(posedge clk); #1;
    @(negedge clk);
    bus8.a = 8'd100; bus8.b = 8'd200;
    d1 = 0; d2 = 0; c1 = '0; c2 = '0; o1 = 1'b0; o2 = 1'b0;
    for (int i = 1; i <= 25; i++) begin
      @(posedge clk); #1;
      if (bus8.done) begin
        if (d1 == 0) begin d1 = i; c1 = bus8.c; o1 = bus8.cout; end
        else if (d2 == 0) begin d2 = i; c2 = bus8.c; o2 = bus8.cout; end
      end
      @(negedge clk);
      if (i == 9) bus8.start = 1'b0;
    end
    chk("b2b first latency", d1, 8);
    chk("b2b period", d2 - d1, 9);
    chk("b2b c1", 32'(c1), 32'h07);
    chk("b2b cout1", 32'(o1), 32'd0);
    chk("b2b c2", 32'(c2), 32'h2C);
    chk("b2b cout2", 32'(o2), 32'd1);

    for (int k = 0; k < 20; k++)
      op8(8'($urandom), 8'($urandom), ($urandom_range(0, 1) == 1), "rand8");

    op4(4'h0, 4'h0, "w4 0+0");
    op4(4'hF, 4'h1, "w4 f+1");
    for (int k = 0; k < 10; k++)
      op4(4'($urandom), 4'($urandom), "rand4");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
